dm_responder: RTL and testbench

//   Responder (memory) end of the CPU data-memory request interface. Accepts one load/store

---
 rtl/dm_responder.sv | 126 ++++++++++++
 tb/tb_dm_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with programmable access latency
module dm_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit SAME_EDGE = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic                  fire_now;
    logic                  access;
    logic                  a_we;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_wdata;
    logic                  a_err;
    logic [DEPTH_LOG2-1:0] a_idx;
    logic [DATA_W-1:0]     a_rdata;
    logic                  mem_wr;

    // With single-cycle latency the access uses the live request, otherwise the latched copy.
    always_comb begin
        fire_now = SAME_EDGE && (state == IDLE) && req_valid;
        access   = fire_now || ((state == WAIT) && (cnt == 4'd1));
        a_we     = fire_now ? req_we    : lat_we;
        a_addr   = fire_now ? req_addr  : lat_addr;
        a_wdata  = fire_now ? req_wdata : lat_wdata;
        a_err    = |a_addr[ADDR_W-1:DEPTH_LOG2];
        a_idx    = a_addr[DEPTH_LOG2-1:0];
        a_rdata  = a_we ? '0 : mem[a_idx];
        mem_wr   = access && a_we && !a_err && !rst;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[a_idx] <= a_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (SAME_EDGE) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= a_rdata;
                            rsp_err   <= a_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= a_rdata;
                        rsp_err   <= a_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // rsp_rdata is left as-is after consumption.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed bench for dm_responder at latencies 2, 4 and 1
module tb_dm_responder;

    logic        clk;
    logic [2:0]  rst_v, rv, rr, we, rdy, vld, er, bsy;
    logic [15:0] addr [3];
    logic [15:0] wd   [3];
    logic [15:0] rd   [3];
    int          checks, failures;

    dm_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst_v[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .rsp_valid(vld[0]), .rsp_ready(rr[0]),
        .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bsy[0]));

    dm_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst_v[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .rsp_valid(vld[1]), .rsp_ready(rr[1]),
        .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bsy[1]));

    dm_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst_v[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(we[2]),
        .req_addr(addr[2]), .req_wdata(wd[2]), .rsp_valid(vld[2]), .rsp_ready(rr[2]),
        .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
        chk("req_ready_idle", 32'(rdy[k]), 1);
        rv[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d;
        @(posedge clk); #1;
        rv[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, input int lat);
        int n = 0;
        while (!vld[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("edges_to_rsp_valid", n, lat - 1);
    endtask

    task automatic txn(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int lat, input logic [15:0] exp_rd, input logic exp_err);
        rr[k] = 1'b1;
        issue(k, w, a, d);
        wait_rsp(k, lat);
        chk("rsp_rdata", 32'(rd[k]), 32'(exp_rd));
        chk("rsp_err", 32'(er[k]), 32'(exp_err));
        @(posedge clk); #1;
        chk("rsp_valid_after_consume", 32'(vld[k]), 0);
        chk("busy_after_consume", 32'(bsy[k]), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy_before;
        int   j;
        logic [15:0] exp6 [4];
        checks = 0; failures = 0;
        rst_v = 3'b111; rv = '0; rr = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wd[i] = '0; end
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_req_ready", 32'(rdy[k]), 1);
            chk("reset_rsp_valid", 32'(vld[k]), 0);
            chk("reset_busy", 32'(bsy[k]), 0);
        end
        rst_v = 3'b000;
        @(posedge clk); #1;

        // Store then load at latency 2
        txn(0, 1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000, 1'b0);
        txn(0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b0);

        // Held response, request presented during RESP must be ignored
        rr[0] = 1'b0;
        issue(0, 1'b0, 16'h0010, 16'h0000);
        wait_rsp(0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wd[0] = 16'h1111; end
            chk("hold_rsp_valid", 32'(vld[0]), 1);
            chk("hold_rsp_rdata", 32'(rd[0]), 32'hBEEF);
            chk("hold_busy", 32'(bsy[0]), 1);
            chk("hold_req_ready", 32'(rdy[0]), 0);
            @(posedge clk); #1;
        end
        rv[0] = 1'b0; rr[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold_released", 32'(vld[0]), 0);
        txn(0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b0);

        // Mid-cycle reset while a response is pending
        rr[0] = 1'b0;
        issue(0, 1'b0, 16'h0010, 16'h0000);
        wait_rsp(0, 2);
        chk("pre_reset_rdata", 32'(rd[0]), 32'hBEEF);
        #3 rst_v[0] = 1'b1;
        #1;
        chk("async_rst_req_ready", 32'(rdy[0]), 1);
        chk("async_rst_rsp_valid", 32'(vld[0]), 0);
        chk("async_rst_rsp_rdata", 32'(rd[0]), 0);
        chk("async_rst_rsp_err", 32'(er[0]), 0);
        chk("async_rst_busy", 32'(bsy[0]), 0);
        #2 rst_v[0] = 1'b0;
        @(posedge clk); #1;

        // Out-of-range store dropped, aliased load flags err
        txn(0, 1'b1, 16'h8010, 16'h1234, 2, 16'h0000, 1'b1);
        txn(0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b0);
        txn(0, 1'b0, 16'h8010, 16'h0000, 2, 16'hBEEF, 1'b1);

        // Reset in WAIT aborts the store at latency 4
        txn(1, 1'b1, 16'h0020, 16'h5555, 4, 16'h0000, 1'b0);
        issue(1, 1'b1, 16'h0020, 16'hAAAA);
        @(posedge clk); #1;
        chk("l4_busy_in_wait", 32'(bsy[1]), 1);
        @(posedge clk); #1;
        rst_v[1] = 1'b1;
        #10 rst_v[1] = 1'b0;
        j = 0;
        for (int i = 0; i < 6; i++) begin
            if (vld[1]) j++;
            @(posedge clk); #1;
        end
        chk("l4_no_rsp_after_reset", j, 0);
        txn(1, 1'b0, 16'h0020, 16'h0000, 4, 16'h5555, 1'b0);

        // Latency 1 back-to-back loads with req_valid held high
        exp6[0] = 16'h1001; exp6[1] = 16'h2002; exp6[2] = 16'h3003; exp6[3] = 16'h4004;
        for (int i = 0; i < 4; i++) txn(2, 1'b1, 16'(i + 1), exp6[i], 1, 16'h0000, 1'b0);
        rr[2] = 1'b1; rv[2] = 1'b1; we[2] = 1'b0;
        j = 0;
        for (int i = 0; i < 8; i++) begin
            addr[2] = 16'(j + 1);
            rdy_before = rdy[2];
            chk("l1_accept_pattern", 32'(rdy_before), 32'((i % 2) == 0));
            @(posedge clk); #1;
            chk("l1_rsp_pulse", 32'(vld[2]), 32'(rdy_before));
            if (rdy_before) begin
                chk("l1_rsp_rdata", 32'(rd[2]), 32'(exp6[j & 3]));
                j++;
            end
        end
        rv[2] = 1'b0;
        chk("l1_accept_count", j, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
